// File: rtl/noc_pkg.sv
// noc_pkg: shared port indices, header field positions and hop-code helpers for the PE/control mesh.
package noc_pkg;
  localparam int NPORT = 5;
  localparam logic [2:0] P_N = 3'd0;
  localparam logic [2:0] P_E = 3'd1;
  localparam logic [2:0] P_S = 3'd2;
  localparam logic [2:0] P_W = 3'd3;
  localparam logic [2:0] P_L = 3'd4;
  typedef enum logic {ROUTE_XY = 1'b0, ROUTE_YX = 1'b1} route_order_e;
  // Header is {dir_x, dir_y, x_hop[COL-1], y_hop[ROW-1], payload} from the MSB down.
  function automatic int x_msb(input int width);
    return width - 3;
  endfunction
  function automatic int x_lsb(input int width, input int col);
    return width - 1 - col;
  endfunction
  function automatic int y_lsb(input int width, input int col, input int row);
    return width - col - row;
  endfunction
  // Left-aligned thermometer: every set bit has a set bit directly above it within the field.
  function automatic logic is_thermo(input logic [31:0] v, input int w);
    logic [31:0] m;
    m = (32'd1 << (w - 1)) - 32'd1;
    return (v & ~(v >> 1) & m) == 32'd0;
  endfunction
endpackage

// File: rtl/router_in_fifo.sv
// router_in_fifo: DEPTH-entry input buffer; pointers carry an extra MSB to tell full from empty.
module router_in_fifo #(
  parameter int WIDTH = 53,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  assign empty = wp_q == rp_q;
  assign full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign head = mem_q[rp_q[AW-1:0]];
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q[AW-1:0]] = push_data;
    wp_d = wp_q + (AW+1)'(push);
    rp_d = rp_q + (AW+1)'(pop & !empty);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/mesh_router_sync.sv
// mesh_router_sync: 5-port clocked mesh router with input FIFOs, thermometer-hop routing,
// per-output round-robin arbitration and registered outputs.
module mesh_router_sync
  import noc_pkg::*;
#(
  parameter int ROW          = 4,
  parameter int COL          = 4,
  parameter int FILTER_WIDTH = 8,
  parameter int WIDTH        = 13 + 5 * FILTER_WIDTH,
  parameter int DEPTH        = 4,
  parameter int ROUTE_ORDER  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           in_valid,
  output logic [4:0]           in_ready,
  input  logic [5*WIDTH-1:0]   in_data,
  output logic [4:0]           out_valid,
  input  logic [4:0]           out_ready,
  output logic [5*WIDTH-1:0]   out_data,
  output logic                 err_pulse,
  output logic [7:0]           drop_cnt
);
  localparam int XH = x_msb(WIDTH);
  localparam int XL = x_lsb(WIDTH, COL);
  localparam int YH = XL - 1;
  localparam int YL = y_lsb(WIDTH, COL, ROW);
  localparam bit YX = ROUTE_ORDER == int'(ROUTE_YX);
  logic [4:0] full, empty, pop, bad, use_x, use_y, gnt, ld_ok;
  logic [4:0] out_valid_q, out_valid_d;
  logic [WIDTH-1:0] head [NPORT];
  logic [WIDTH-1:0] nflit [NPORT];
  logic [WIDTH-1:0] out_q [NPORT];
  logic [WIDTH-1:0] out_d [NPORT];
  logic [2:0] dst [NPORT];
  logic [2:0] win [NPORT];
  logic [2:0] ptr_q [NPORT];
  logic [2:0] ptr_d [NPORT];
  logic [3:0] t;
  logic [2:0] idx;
  logic err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
  for (genvar g = 0; g < NPORT; g++) begin : g_port
    router_in_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk(clk), .rst(rst),
      .push(in_valid[g] & !full[g]), .push_data(in_data[g*WIDTH +: WIDTH]),
      .pop(pop[g]), .full(full[g]), .empty(empty[g]), .head(head[g])
    );
    assign out_data[g*WIDTH +: WIDTH] = out_q[g];
  end
  assign in_ready = ~full;
  assign out_valid = out_valid_q;
  assign err_pulse = err_q;
  assign drop_cnt = cnt_q;
  always_comb
    for (int i = 0; i < NPORT; i++) begin
      nflit[i] = head[i];
      use_x[i] = |head[i][XH:XL] & (!YX | ~|head[i][YH:YL]);
      use_y[i] = |head[i][YH:YL] & !use_x[i];
      dst[i] = use_x[i] ? (head[i][WIDTH-1] ? P_E : P_W) : use_y[i] ? (head[i][WIDTH-2] ? P_N : P_S) : P_L;
      if (use_x[i]) nflit[i][XH:XL] = head[i][XH:XL] << 1;
      if (use_y[i]) nflit[i][YH:YL] = head[i][YH:YL] << 1;
      bad[i] = !empty[i] & (!is_thermo(32'(head[i][XH:XL]), COL - 1) |
                            !is_thermo(32'(head[i][YH:YL]), ROW - 1) | dst[i] == 3'(i));
    end
  // Scan from pointer+4 down to pointer so the request closest to the pointer wins last.
  always_comb begin
    t = '0;
    idx = '0;
    for (int o = 0; o < NPORT; o++) begin
      ld_ok[o] = !out_valid_q[o] | out_ready[o];
      gnt[o] = 1'b0;
      win[o] = '0;
      for (int k = NPORT - 1; k >= 0; k--) begin
        t = 4'(ptr_q[o]) + 4'(k);
        idx = t >= 4'd5 ? 3'(t - 4'd5) : 3'(t);
        if (!empty[idx] && !bad[idx] && dst[idx] == 3'(o) && ld_ok[o]) begin
          win[o] = idx;
          gnt[o] = 1'b1;
        end
      end
      out_valid_d[o] = gnt[o] | (out_valid_q[o] & !out_ready[o]);
      out_d[o] = gnt[o] ? nflit[win[o]] : out_q[o];
      ptr_d[o] = gnt[o] ? (win[o] == 3'd4 ? 3'd0 : win[o] + 3'd1) : ptr_q[o];
    end
    cnt_d = cnt_q;
    for (int i = 0; i < NPORT; i++) begin
      pop[i] = bad[i] | (!empty[i] & gnt[dst[i]] & win[dst[i]] == 3'(i));
      if (bad[i] && cnt_d != 8'hff) cnt_d = cnt_d + 8'd1;
    end
    err_d = |bad;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
      for (int o = 0; o < NPORT; o++) begin
        out_q[o] <= '0;
        ptr_q[o] <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      for (int o = 0; o < NPORT; o++) begin
        out_q[o] <= out_d[o];
        ptr_q[o] <= ptr_d[o];
      end
    end
endmodule

// File: tb/tb_mesh_router_sync.sv
// tb_mesh_router_sync: scoreboard bench; a hop-count reference model predicts each accepted flit's exit.
module tb_mesh_router_sync;
  localparam int W = 53;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] in_valid, in_ready, out_valid, out_ready, y_in_valid, y_in_ready, y_out_valid;
  logic [5*W-1:0] in_data, out_data, y_in_data, y_out_data;
  logic err_pulse, y_err;
  logic [7:0] drop_cnt, y_cnt;
  int n_vec = 0, n_err = 0, drop_exp = 0;
  logic [4:0] last_acc;
  logic [W-1:0] exp_q [25][$];
  int l_log[$];

  localparam logic [W-1:0] F1 = {1'b1, 1'b0, 3'b100, 3'b000, 45'h1234};
  localparam logic [W-1:0] E1 = {1'b1, 1'b0, 3'b000, 3'b000, 45'h1234};
  localparam logic [W-1:0] F2 = {1'b1, 1'b0, 3'b100, 3'b110, 45'h1234};
  localparam logic [W-1:0] E2X = {1'b1, 1'b0, 3'b000, 3'b110, 45'h1234};
  localparam logic [W-1:0] E2Y = {1'b1, 1'b0, 3'b100, 3'b100, 45'h1234};

  always #5 clk = ~clk;

  mesh_router_sync #(.ROUTE_ORDER(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_pulse(err_pulse), .drop_cnt(drop_cnt)
  );
  mesh_router_sync #(.ROUTE_ORDER(1)) dut_yx (
    .clk(clk), .rst(rst), .in_valid(y_in_valid), .in_ready(y_in_ready), .in_data(y_in_data),
    .out_valid(y_out_valid), .out_ready(5'b11111), .out_data(y_out_data),
    .err_pulse(y_err), .drop_cnt(y_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] thermo(input int n);
    return 3'b111 << (3 - n);
  endfunction

  // Reference routing: count hops, take one from the leading dimension, drop malformed or U-turn.
  function automatic void model(input int p, input logic [W-1:0] f, input bit yx,
                                output bit drop, output int o, output logic [W-1:0] nf);
    int nx, ny;
    nx = $countones(f[50:48]);
    ny = $countones(f[47:45]);
    nf = f;
    o = 4;
    if (nx > 0 && (!yx || ny == 0)) begin
      o = f[52] ? 1 : 3;
      nf[50:48] = thermo(nx - 1);
    end else if (ny > 0) begin
      o = f[51] ? 0 : 2;
      nf[47:45] = thermo(ny - 1);
    end
    drop = f[50:48] != thermo(nx) || f[47:45] != thermo(ny) || o == p;
  endfunction

  function automatic logic [W-1:0] rnd_flit();
    logic [2:0] x, y;
    x = thermo(int'($urandom_range(0, 3)));
    y = thermo(int'($urandom_range(0, 3)));
    if ($urandom_range(0, 19) == 0) x = 3'($urandom);
    return {1'($urandom), 1'($urandom), x, y, 45'({$urandom, $urandom})};
  endfunction

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < 25; i++) s += exp_q[i].size();
    return s;
  endfunction

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    logic [W-1:0] nf;
    bit d;
    int o;
    last_acc = in_valid & in_ready;
    @(posedge clk);
    for (int p = 0; p < 5; p++)
      if (last_acc[p]) begin
        model(p, in_data[p*W +: W], 1'b0, d, o, nf);
        if (d) drop_exp++;
        else exp_q[o*5+p].push_back(nf);
      end
    @(negedge clk);
  endtask

  task automatic drain(input int bound);
    int k = 0;
    in_valid = '0;
    out_ready = '1;
    while (pending() > 0 && k < bound) begin
      tick();
      k++;
    end
    chk("drain_left", 64'(pending()), 0);
  endtask

  always begin
    @(negedge clk);
    #2;
    if (!rst)
      for (int o = 0; o < 5; o++)
        if (out_valid[o] && out_ready[o]) begin
          logic [W-1:0] d;
          int hit;
          d = out_data[o*W +: W];
          hit = -1;
          for (int s = 4; s >= 0; s--)
            if (exp_q[o*5+s].size() > 0 && exp_q[o*5+s][0] == d) hit = s;
          n_vec++;
          if (hit < 0) begin
            n_err++;
            $display("FAIL sb_out%0d: got %h want a queued flit for this output (%0d pending)", o, d, pending());
          end else begin
            void'(exp_q[o*5+hit].pop_front());
            if (o == 4) l_log.push_back(hit);
          end
        end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, g;
    in_valid = '0; in_data = '0; out_ready = '1; y_in_valid = '0; y_in_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_in_ready", 64'(in_ready), 5'b11111);
    chk("rst_drop_cnt", 64'(drop_cnt), 0);
    chk("rst_err", 64'(err_pulse), 0);
    chk("rst_out_data", 64'(out_data[W +: W]), 0);
    rst = 1'b0;

    in_data[3*W +: W] = F1; in_valid = 5'b01000;
    tick();
    in_valid = '0;
    chk("lat_early", 64'(out_valid), 0);
    tick();
    chk("lat_valid", 64'(out_valid), 5'b00010);
    chk("e_data", 64'(out_data[W +: W]), 64'(E1));
    drain(20);

    in_data[3*W +: W] = F2; y_in_data[3*W +: W] = F2;
    in_valid = 5'b01000; y_in_valid = 5'b01000;
    tick();
    in_valid = '0; y_in_valid = '0;
    tick();
    chk("xy_valid", 64'(out_valid), 5'b00010);
    chk("xy_data", 64'(out_data[W +: W]), 64'(E2X));
    chk("yx_valid", 64'(y_out_valid), 5'b00100);
    chk("yx_data", 64'(y_out_data[2*W +: W]), 64'(E2Y));
    drain(20);

    l_log.delete();
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 4; p++) in_data[p*W +: W] = {8'h00, 45'(k*16 + p)};
      in_valid = 5'b01101;
      tick();
    end
    in_valid = '0;
    drain(40);
    chk("rr_cnt", 64'(l_log.size()), 9);
    for (int i = 0; i < l_log.size() && i < 9; i++)
      chk("rr_order", 64'(l_log[i]), (i % 3 == 0) ? 0 : (i % 3 == 1) ? 2 : 3);

    out_ready = 5'b11101; sent = 0; g = 0; in_valid = 5'b01000;
    while (sent < 5 && g < 20) begin
      in_data[3*W +: W] = {1'b1, 1'b0, 3'b100, 3'b000, 45'(200 + sent)};
      tick();
      if (last_acc[3]) sent++;
      g++;
    end
    in_valid = '0;
    chk("bp_sent", 64'(sent), 5);
    chk("bp_in_ready", 64'(in_ready), 5'b10111);
    repeat (3) begin
      tick();
      chk("bp_hold_v", 64'(out_valid[1]), 1);
      chk("bp_hold_d", 64'(out_data[W +: W]), 64'({1'b1, 1'b0, 3'b000, 3'b000, 45'd200}));
    end
    drain(30);

    in_data[W +: W] = {1'b1, 1'b0, 3'b010, 3'b000, 45'h55}; in_valid = 5'b00010;
    tick();
    in_valid = '0;
    chk("bad_err0", 64'(err_pulse), 0);
    tick();
    chk("bad_err1", 64'(err_pulse), 1);
    chk("bad_cnt1", 64'(drop_cnt), 1);
    chk("bad_nov", 64'(out_valid), 0);
    tick();
    chk("bad_err2", 64'(err_pulse), 0);
    in_data[W +: W] = {1'b1, 1'b0, 3'b100, 3'b000, 45'h66}; in_valid = 5'b00010;
    tick();
    in_valid = '0;
    tick();
    chk("uturn_cnt", 64'(drop_cnt), 2);
    chk("uturn_nov", 64'(out_valid), 0);

    repeat (300) begin
      for (int p = 0; p < 5; p++) in_data[p*W +: W] = rnd_flit();
      in_valid = 5'($urandom);
      out_ready = 5'($urandom) | 5'($urandom);
      tick();
    end
    drain(300);
    chk("drop_cnt", 64'(drop_cnt), drop_exp > 255 ? 255 : drop_exp);

    out_ready = 5'b11101; sent = 0; g = 0; in_valid = 5'b01000;
    while (sent < 4 && g < 20) begin
      in_data[3*W +: W] = {1'b1, 1'b0, 3'b100, 3'b000, 45'(300 + sent)};
      tick();
      if (last_acc[3]) sent++;
      g++;
    end
    in_valid = '0;
    chk("ar_pre_v", 64'(out_valid), 5'b00010);
    #4 rst = 1'b1;
    #1;
    chk("ar_out_valid", 64'(out_valid), 0);
    chk("ar_in_ready", 64'(in_ready), 5'b11111);
    chk("ar_out_data", 64'(out_data[W +: W]), 0);
    for (int i = 0; i < 25; i++) exp_q[i].delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = '1;
    repeat (8) tick();
    chk("ar_post_v", 64'(out_valid), 0);
    chk("ar_post_cnt", 64'(drop_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
